// File: rtl/ffo_pkg.sv
// rtl/ffo_pkg.sv - shared state type and index-width helper for the first-one scanner
package ffo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMPTY
  } state_t;

  function automatic int idx_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/ffo_scanner_if.sv
// rtl/ffo_scanner_if.sv - vector-in / index-beat-out handshake bundle of the scanner
interface ffo_scanner_if #(
  parameter int N = 32
);
  import ffo_pkg::*;

  localparam int IW = idx_width(N);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_dir;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic [IW-1:0] out_seq;
  logic          out_last;
  logic          out_zero;

  modport master (
    output in_valid, in_data, in_dir, out_ready,
    input  in_ready, out_valid, out_idx, out_seq, out_last, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_dir, out_ready,
    output in_ready, out_valid, out_idx, out_seq, out_last, out_zero
  );

endinterface

// File: rtl/ffo_tree.sv
// rtl/ffo_tree.sv - recursive leading-one finder; pos counts down from bit N-1
module ffo_tree
  import ffo_pkg::*;
#(
  parameter int N = 32,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  data,
  output logic          valid,
  output logic [IW-1:0] pos
);

  if (N == 2) begin : g_leaf
    assign valid = data[1] | data[0];
    assign pos   = ~data[1];
  end else begin : g_node
    logic          hi_valid;
    logic          lo_valid;
    logic [IW-2:0] hi_pos;
    logic [IW-2:0] lo_pos;

    ffo_tree #(.N(N / 2)) u_hi (
      .data  (data[N-1:N/2]),
      .valid (hi_valid),
      .pos   (hi_pos)
    );

    ffo_tree #(.N(N / 2)) u_lo (
      .data  (data[N/2-1:0]),
      .valid (lo_valid),
      .pos   (lo_pos)
    );

    // The upper half wins whenever it holds a one, so its pos gets a 0 MSB.
    assign valid = hi_valid | lo_valid;
    assign pos   = hi_valid ? {1'b0, hi_pos} : {1'b1, lo_pos};
  end

endmodule

// File: rtl/ffo_scanner.sv
// rtl/ffo_scanner.sv - streams the index of every set bit of an accepted vector, one per cycle
module ffo_scanner
  import ffo_pkg::*;
#(
  parameter int N = 32
) (
  input  logic          clock,
  input  logic          reset,
  ffo_scanner_if.slave  bus
);

  localparam int IW = idx_width(N);

  state_t        state, state_n;
  logic [N-1:0]  w, w_n;
  logic          d, d_n;
  logic [IW-1:0] seq, seq_n;

  logic [N-1:0]  w_rev;
  logic [N-1:0]  scan_vec;
  logic          found;
  logic [IW-1:0] pos;
  logic [IW-1:0] idx;
  logic [N-1:0]  clr_mask;
  logic [N-1:0]  w_clr;
  logic          last;

  logic          in_ready;
  logic          out_valid;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          out_zero;

  always_comb begin
    w_rev = '0;
    for (int i = 0; i < N; i++) begin
      w_rev[i] = w[N-1-i];
    end
  end

  // LSB-first reuses the MSB-first tree by mirroring the work register.
  assign scan_vec = d ? w_rev : w;

  ffo_tree #(.N(N)) u_tree (
    .data  (scan_vec),
    .valid (found),
    .pos   (pos)
  );

  assign idx      = d ? pos : (IW'(N - 1) - pos);
  assign clr_mask = {{(N-1){1'b0}}, 1'b1} << idx;
  assign w_clr    = w & ~clr_mask;
  assign last     = found & (w_clr == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      w     <= '0;
      d     <= 1'b0;
      seq   <= '0;
    end else begin
      state <= state_n;
      w     <= w_n;
      d     <= d_n;
      seq   <= seq_n;
    end
  end

  always_comb begin
    state_n   = state;
    w_n       = w;
    d_n       = d;
    seq_n     = seq;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    out_last  = 1'b0;
    out_zero  = 1'b0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
      end
      SCAN: begin
        out_valid = 1'b1;
        out_idx   = idx;
        out_last  = last;
        if (bus.out_ready) begin
          w_n   = w_clr;
          seq_n = seq + IW'(1);
          if (last) begin
            // Clearing seq here keeps an all-ones vector from wrapping it.
            in_ready = 1'b1;
            state_n  = IDLE;
            seq_n    = '0;
          end
        end
      end
      EMPTY: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_zero  = 1'b1;
        if (bus.out_ready) begin
          in_ready = 1'b1;
          state_n  = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // A new vector overrides the return to IDLE so back-to-back vectors need no bubble.
    if (bus.in_valid && in_ready) begin
      w_n     = bus.in_data;
      d_n     = bus.in_dir;
      seq_n   = '0;
      state_n = (bus.in_data != '0) ? SCAN : EMPTY;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_idx   = out_idx;
  assign bus.out_seq   = seq;
  assign bus.out_last  = out_last;
  assign bus.out_zero  = out_zero;

endmodule

// File: tb/tb_ffo_scanner.sv
// tb/tb_ffo_scanner.sv - table-driven and scoreboard bench for ffo_scanner at N=8
module tb_ffo_scanner;

  localparam int N = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  ffo_scanner_if #(.N(N)) bus ();

  ffo_scanner #(.N(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0] idx;
    logic [2:0] seq;
    logic       last;
    logic       zero;
  } beat_t;

  typedef struct packed {
    logic [7:0]  data;
    logic        dir;
    logic [3:0]  nb;
    logic [31:0] idxs;
    logic        ez;
  } vec_t;

  beat_t exp_q[$];
  beat_t mon_got;
  beat_t mon_exp;
  vec_t  vecs[9];
  int    checks   = 0;
  int    failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      mon_got = {bus.out_idx, bus.out_seq, bus.out_last, bus.out_zero};
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual=%0h required=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        check("beat", 32'(mon_got), 32'(mon_exp));
      end
    end
  end

  task automatic send(input vec_t v);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = v.data;
    bus.in_dir   = v.dir;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("in_ready_timeout", 32'(ok), 32'd1);
    for (int k = 0; k < int'(v.nb); k++) begin
      exp_q.push_back({v.idxs[4*k +: 3], 3'(k), (k == int'(v.nb) - 1), v.ez});
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    bus.in_dir   = 1'($urandom);
    @(negedge clock);
    check("first_beat", {bus.out_valid, 1'b0, bus.out_idx, 1'b0, bus.out_seq},
          {1'b1, 1'b0, v.idxs[2:0], 1'b0, 3'd0});
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 40; c++) begin
      @(posedge clock);
      #1;
      if (exp_q.size() == 0) break;
    end
    check({name, "_drain"}, exp_q.size(), 0);
    check({name, "_idle"}, {bus.out_valid, bus.in_ready}, 2'b01);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA4, 1'b0, 4'd3, 32'h0000_0257, 1'b0};
    vecs[1] = '{8'hA4, 1'b1, 4'd3, 32'h0000_0752, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 4'd1, 32'h0000_0000, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 4'd1, 32'h0000_0000, 1'b1};
    vecs[4] = '{8'h81, 1'b1, 4'd2, 32'h0000_0070, 1'b0};
    vecs[5] = '{8'h3C, 1'b0, 4'd4, 32'h0000_2345, 1'b0};
    vecs[6] = '{8'h80, 1'b1, 4'd1, 32'h0000_0007, 1'b0};
    vecs[7] = '{8'hFF, 1'b1, 4'd8, 32'h7654_3210, 1'b0};
    vecs[8] = '{8'h01, 1'b0, 4'd1, 32'h0000_0000, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_dir    = 1'b0;
    bus.out_ready = 1'b1;

    #1 reset = 1'b1;
    #2;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready",  bus.in_ready,  1'b1);
    check("rst_out_last",  bus.out_last,  1'b0);
    check("rst_out_zero",  bus.out_zero,  1'b0);
    check("rst_out_idx",   bus.out_idx,   3'd0);
    check("rst_out_seq",   bus.out_seq,   3'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      send(vecs[i]);
      wait_drain("table");
    end

    bus.out_ready = 1'b0;
    send('{8'hFF, 1'b0, 4'd8, 32'h0123_4567, 1'b0});
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("stall_hold", {bus.out_valid, bus.out_idx, bus.out_seq, bus.out_last, bus.out_zero},
            {1'b1, 3'd7, 3'd0, 1'b0, 1'b0});
    end
    @(posedge clock);
    #1 bus.out_ready = 1'b1;
    wait_drain("stall");

    send('{8'h81, 1'b0, 4'd2, 32'h0000_0007, 1'b0});
    send('{8'h01, 1'b0, 4'd1, 32'h0000_0000, 1'b0});
    wait_drain("b2b");

    send('{8'hFF, 1'b0, 4'd8, 32'h0123_4567, 1'b0});
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("abort_remaining", exp_q.size(), 5);
    check("abort_out_valid", bus.out_valid, 1'b0);
    check("abort_in_ready",  bus.in_ready,  1'b1);
    exp_q.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("post_abort_idle", bus.out_valid, 1'b0);
    send('{8'h10, 1'b0, 4'd1, 32'h0000_0004, 1'b0});
    wait_drain("post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ffo_scanner.md
FFO_SCANNER -- requirements
Module: ffo_scanner

Interface
REQ-001 Parameter N, default 32, SHALL set the scanned vector width; legal values are powers of two, 4 to 256.
REQ-002 Localparam IW = $clog2(N) SHALL set the index width.
REQ-003 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  input vector offered.
REQ-006 in_ready  out  1  scanner can accept a vector.
REQ-007 in_data  in  N  vector to scan.
REQ-008 in_dir  in  1  scan direction: 0 = bit N-1 downward (MSB-first), 1 = bit 0 upward (LSB-first).
REQ-009 out_valid  out  1  index beat present.
REQ-010 out_ready  in  1  consumer accepts the beat.
REQ-011 out_idx  out  IW  bit index of the current set bit.
REQ-012 out_seq  out  IW  0-based beat number within the current vector.
REQ-013 out_last  out  1  final beat of the current vector.
REQ-014 out_zero  out  1  the accepted vector was all zeros.

Function
REQ-015 States SHALL be IDLE, SCAN and EMPTY.
REQ-016 in_ready SHALL be 1 in IDLE, and 1 in SCAN/EMPTY only when out_valid & out_ready & out_last; otherwise 0.
REQ-017 An input handshake SHALL register in_data into work register W and in_dir into D, and clear out_seq to 0; next state is SCAN if in_data != 0, else EMPTY.
REQ-018 out_valid SHALL be 1 in SCAN and EMPTY, 0 in IDLE; first beat appears the cycle after the input handshake (latency 1).
REQ-019 In SCAN, out_idx SHALL be the highest set bit of W when D=0, the lowest set bit of W when D=1; out_zero=0.
REQ-020 In SCAN, out_last SHALL be 1 iff W has exactly one set bit.
REQ-021 On an output handshake in SCAN, the bit at out_idx SHALL be cleared in W and out_seq incremented; if out_last, next state is IDLE unless a simultaneous input handshake occurs (REQ-017 takes priority, no bubble).
REQ-022 In EMPTY, outputs SHALL be out_idx=0, out_seq=0, out_last=1, out_zero=1; on handshake, go to IDLE or accept a new vector per REQ-021.
REQ-023 While out_valid=1 and out_ready=0, out_idx, out_seq, out_last and out_zero SHALL hold stable.
REQ-024 Throughput SHALL be one index per cycle; an all-ones vector yields N beats, out_seq 0..N-1, with no wrap of out_seq.
REQ-025 in_data and in_dir SHALL be ignored except during an input handshake.

Reset
REQ-026 Reset SHALL force state IDLE, W=0, D=0, out_seq=0; hence out_valid=0, in_ready=1, out_last=0, out_zero=0, out_idx=0, immediately and independently of clock.
REQ-027 Reset during SCAN/EMPTY SHALL abort the vector; remaining indices are discarded and never emitted.

Structure
REQ-028 Package ffo_pkg SHALL hold the state enum typedef and the index-width helper function; no other constants.
REQ-029 Sub-module ffo_tree (parameter N) SHALL be the combinational recursive leading-one tree: valid/position pairs merged per level (left half valid selects left position, MSB of position = ~left valid); it reports position from bit N-1.
REQ-030 LSB-first SHALL reuse the same ffo_tree on bit-reversed W; out_idx = N-1-pos for D=0, pos for D=1.
REQ-031 out_last SHALL be computed as (W with found bit cleared) == 0, not by a popcount.

Verification (N=8)
REQ-032 in_data=8'hA4, dir=0, out_ready=1 -> out_idx 7,5,2; out_seq 0,1,2; out_last on the third beat only; then IDLE.
REQ-033 in_data=8'hA4, dir=1 -> out_idx 2,5,7; out_last on idx 7.
REQ-034 in_data=8'h00 -> single beat out_zero=1, out_last=1, out_idx=0, out_seq=0.
REQ-035 in_data=8'hFF, out_ready low for cycles 2-4 -> idx 7 held stable, then 6..0, out_seq reaches 7, 8 beats total.
REQ-036 Back-to-back: 8'h81 then 8'h01 offered during the last beat -> accepted on the same edge, next cycle out_idx=0, out_seq=0, no idle cycle.
REQ-037 Reset asserted after 3 beats of 8'hFF -> out_valid=0, in_ready=1 asynchronously; the next vector 8'h10 yields idx 4, seq 0.
